// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with two combinational read ports and one
// byte-enabled write port. It also holds a per-register scoreboard of
// outstanding writes and a scrub engine that sweeps every register to zero.
//
// Parameters
//    XLEN     - register width in bits (multiple of 8)
//    NREGS    - register count (power of two, >= 2)
//    AW       - address width, log2(NREGS)
//    ZERO_REG - 1: register 0 is hard-wired to zero, with no pending bit
//    BYPASS   - 1: write data is forwarded to matching reads in the same cycle
//
// Ports
//    clk                    in   single clock, rising edge
//    clear                  in   asynchronous active-low reset
//    wr_en/wr_addr/wr_data  in   write request, address and data
//    wr_be                  in   byte enables; bit k covers bits 8k+7..8k
//    rd_addr_a/rd_addr_b    in   read addresses
//    rd_data_a/rd_data_b    out  read data (zero latency)
//    sb_set/sb_addr         in   mark a register as having a write outstanding
//    pend_a/pend_b          out  scoreboard bit of rd_addr_a / rd_addr_b
//    scrub_req              in   start a sweep that clears every register
//    scrub_busy             out  sweep in progress
//    scrub_done             out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module reg_file_param #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic [XLEN/8-1:0] wr_be,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [XLEN-1:0]   rd_data_a,
   output logic [XLEN-1:0]   rd_data_b,
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   output logic              pend_a,
   output logic              pend_b,
   input  logic              scrub_req,
   output logic              scrub_busy,
   output logic              scrub_done
);

   localparam int            NB   = XLEN / 8;
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t            state_reg;
   logic [AW-1:0]     cnt_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [XLEN-1:0]   mem [NREGS];
   logic [NREGS-1:0]  pend_reg;

   logic              idle;
   logic              wr_zero;
   logic              sb_zero;
   logic              wr_ok;
   logic              sb_ok;
   logic [XLEN-1:0]   wr_old;
   logic [XLEN-1:0]   wr_merged;
   logic              rd_zero_a;
   logic              rd_zero_b;
   logic              byp_a;
   logic              byp_b;

   // Writes and scoreboard sets are only honoured while the scrub engine is
   // idle; the zero register swallows both.
   assign idle    = (state_reg == IDLE);
   assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
   assign sb_zero = (ZERO_REG != 0) && (sb_addr == '0);
   assign wr_ok   = idle && wr_en && !wr_zero;
   assign sb_ok   = idle && sb_set && !sb_zero;

   // Byte-merged write value: new bytes where enabled, stored bytes elsewhere.
   // The same value feeds both the array update and the read bypass.
   assign wr_old = mem[wr_addr];

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_merge
         assign wr_merged[gi*8 +: 8] = wr_be[gi] ? wr_data[gi*8 +: 8]
                                                 : wr_old[gi*8 +: 8];
      end
   endgenerate

   // Read ports. wr_ok already excludes the zero register and non-idle
   // states, so the bypass never fires for either.
   assign rd_zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
   assign rd_zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
   assign byp_a     = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a);
   assign byp_b     = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b);

   assign rd_data_a = rd_zero_a ? '0 : (byp_a ? wr_merged : mem[rd_addr_a]);
   assign rd_data_b = rd_zero_b ? '0 : (byp_b ? wr_merged : mem[rd_addr_b]);

   // Pending bits are reported from storage only; a same-cycle sb_set shows
   // up one cycle later.
   assign pend_a = rd_zero_a ? 1'b0 : pend_reg[rd_addr_a];
   assign pend_b = rd_zero_b ? 1'b0 : pend_reg[rd_addr_b];

   assign scrub_busy = busy_reg;
   assign scrub_done = done_reg;

   // Register storage
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (state_reg == SWEEP) begin
         mem[cnt_reg] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   // Scoreboard. The set is written after the clear so that a set and an
   // accepted write to the same address leave the bit at 1.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         pend_reg <= '0;
      end else if (state_reg == SWEEP) begin
         pend_reg[cnt_reg] <= 1'b0;
      end else begin
         if (wr_ok) begin
            pend_reg[wr_addr] <= 1'b0;
         end
         if (sb_ok) begin
            pend_reg[sb_addr] <= 1'b1;
         end
      end
   end

   // Scrub FSM with registered busy/done flags. cnt stops at LAST and is
   // returned to 0 on the way to DONE, so it never wraps inside a sweep.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (scrub_req) begin
                  state_reg <= SWEEP;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            SWEEP: begin
               if (cnt_reg == LAST) begin
                  state_reg <= DONE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Self-checking bench for reg_file_param. Two instances share all inputs:
// dut_b has BYPASS=1 and dut_n has BYPASS=0. The bench runs a directed
// vector table, then randomized traffic checked against an array model,
// then hand-written scrub and reset-mid-sweep sequences.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

   logic        clk;
   logic        clear;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [3:0]  be;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic        sb;
   logic [4:0]  sa;
   logic        scrub_req;

   logic [31:0] rda_b, rdb_b, rda_n, rdb_n;
   logic        pa_b, pb_b, pa_n, pb_n;
   logic        busy_b, done_b, busy_n, done_n;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [32];
   logic        model_pend [32];

   reg_file_param #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .clear(clear), .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_be(be),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda_b), .rd_data_b(rdb_b),
      .sb_set(sb), .sb_addr(sa), .pend_a(pa_b), .pend_b(pb_b),
      .scrub_req(scrub_req), .scrub_busy(busy_b), .scrub_done(done_b)
   );

   reg_file_param #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
      .clk(clk), .clear(clear), .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_be(be),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda_n), .rd_data_b(rdb_n),
      .sb_set(sb), .sb_addr(sa), .pend_a(pa_n), .pend_b(pb_n),
      .scrub_req(scrub_req), .scrub_busy(busy_n), .scrub_done(done_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (required: finish before 200000)");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; wa = '0; wd = '0; be = '0; sb = 1'b0; sa = '0; scrub_req = 1'b0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] en);
      logic [31:0] m;
      m = 32'h0;
      for (int k = 0; k < 4; k++) begin
         if (en[k]) m = m | (32'hFF << (8 * k));
      end
      return (new_v & m) | (old_v & ~m);
   endfunction

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        sb;
      logic [4:0]  sa;
      logic [4:0]  ra;
      logic [31:0] exp_byp;
      logic [31:0] exp_nb;
      logic        exp_pend;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          busy_cnt_b, busy_cnt_n, done_cnt_b, done_cnt_n, done_at;
      logic [31:0] ea_b, eb_b, ea_n, eb_n, st_a, st_b;
      logic        ep_a, ep_b;

      // we, wa, wd, be, sb, sa, ra, exp_byp, exp_nb, exp_pend
      vecs[0]  = '{1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 1'b0, 5'd0, 5'd5, 32'hAABBCCDD, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 5'd5, 32'h11223344, 4'h5, 1'b0, 5'd0, 5'd5, 32'hAA22CC44, 32'hAABBCCDD, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b0, 5'd0, 5'd5, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
      vecs[3]  = '{1'b1, 5'd7, 32'h12345678, 4'h3, 1'b0, 5'd0, 5'd7, 32'h00005678, 32'h00000000, 1'b0};
      vecs[4]  = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b0, 5'd0, 5'd7, 32'h00005678, 32'h00005678, 1'b0};
      vecs[5]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 1'b0};
      vecs[6]  = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b0, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 1'b0};
      vecs[7]  = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b1, 5'd9, 5'd9, 32'h00000000, 32'h00000000, 1'b0};
      vecs[8]  = '{1'b1, 5'd9, 32'hFFFFFFFF, 4'h0, 1'b1, 5'd9, 5'd9, 32'h00000000, 32'h00000000, 1'b1};
      vecs[9]  = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b0, 5'd0, 5'd9, 32'h00000000, 32'h00000000, 1'b1};
      vecs[10] = '{1'b1, 5'd9, 32'h00000055, 4'hF, 1'b0, 5'd0, 5'd9, 32'h00000055, 32'h00000000, 1'b1};
      vecs[11] = '{1'b0, 5'd0, 32'h00000000, 4'h0, 1'b0, 5'd0, 5'd9, 32'h00000055, 32'h00000055, 1'b0};

      // ---------------- reset ----------------
      clear = 1'b1;
      idle_inputs();
      ra = '0; rb = '0;
      #2 clear = 1'b0;
      step();
      step();
      chk("reset_busy", {31'b0, busy_b}, 32'h0);
      chk("reset_done", {31'b0, done_b}, 32'h0);
      for (int a = 0; a < 32; a += 7) begin
         ra = 5'(a); rb = 5'(31 - a);
         #1;
         chk($sformatf("reset_rd_a[%0d]", a), rda_b, 32'h0);
         chk($sformatf("reset_rd_b[%0d]", 31 - a), rdb_n, 32'h0);
         chk($sformatf("reset_pend[%0d]", a), {31'b0, pa_b}, 32'h0);
      end
      step();
      clear = 1'b1;

      // ---------------- directed table ----------------
      rb = 5'd0;
      for (int i = 0; i < 12; i++) begin
         we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; be = vecs[i].be;
         sb = vecs[i].sb; sa = vecs[i].sa; ra = vecs[i].ra;
         #2;
         chk($sformatf("vec%0d rd_a bypass", i), rda_b, vecs[i].exp_byp);
         chk($sformatf("vec%0d rd_a nobypass", i), rda_n, vecs[i].exp_nb);
         chk($sformatf("vec%0d pend_a", i), {31'b0, pa_b}, {31'b0, vecs[i].exp_pend});
         chk($sformatf("vec%0d pend_a nb", i), {31'b0, pa_n}, {31'b0, vecs[i].exp_pend});
         $display("vec %0d: wr_en=%0b addr=%0d data=%08h be=%h sb=%0b@%0d rd_a[%0d]=%08h/%08h pend=%0b",
                  i, we, wa, wd, be, sb, sa, ra, rda_b, rda_n, pa_b);
         @(posedge clk); #1;
      end
      idle_inputs();

      // ---------------- randomized traffic vs model ----------------
      for (int i = 0; i < 32; i++) begin
         model_mem[i]  = 32'h0;
         model_pend[i] = 1'b0;
      end
      model_mem[5] = 32'hAA22CC44;
      model_mem[7] = 32'h00005678;
      model_mem[9] = 32'h00000055;

      for (int t = 0; t < 400; t++) begin
         we = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom; be = 4'($urandom);
         sb = ($urandom_range(0, 3) == 0); sa = 5'($urandom);
         ra = 5'($urandom); rb = 5'($urandom);
         if (t % 5 == 0) ra = wa;
         if (t % 7 == 0) rb = wa;
         st_a = (ra == 0) ? 32'h0 : model_mem[ra];
         st_b = (rb == 0) ? 32'h0 : model_mem[rb];
         ea_n = st_a; eb_n = st_b;
         ea_b = (we && wa == ra && ra != 0) ? merge(st_a, wd, be) : st_a;
         eb_b = (we && wa == rb && rb != 0) ? merge(st_b, wd, be) : st_b;
         ep_a = (ra == 0) ? 1'b0 : model_pend[ra];
         ep_b = (rb == 0) ? 1'b0 : model_pend[rb];
         #2;
         chk("rand rd_a bypass", rda_b, ea_b);
         chk("rand rd_b bypass", rdb_b, eb_b);
         chk("rand rd_a nobypass", rda_n, ea_n);
         chk("rand rd_b nobypass", rdb_n, eb_n);
         chk("rand pend_a", {31'b0, pa_b}, {31'b0, ep_a});
         chk("rand pend_b", {31'b0, pb_b}, {31'b0, ep_b});
         chk("rand pend_a nb", {31'b0, pa_n}, {31'b0, ep_a});
         chk("rand pend_b nb", {31'b0, pb_n}, {31'b0, ep_b});
         $display("rand %0d: wr_en=%0b addr=%0d data=%08h be=%h sb=%0b@%0d rd_a[%0d]=%08h rd_b[%0d]=%08h",
                  t, we, wa, wd, be, sb, sa, ra, rda_b, rb, rdb_b);
         if (we && wa != 0) begin
            model_mem[wa]  = merge(model_mem[wa], wd, be);
            model_pend[wa] = 1'b0;
         end
         if (sb && sa != 0) model_pend[sa] = 1'b1;
         @(posedge clk); #1;
      end
      idle_inputs();

      // ---------------- full sweep ----------------
      for (int a = 0; a < 32; a++) begin
         we = 1'b1; wa = 5'(a); wd = $urandom | 32'h1; be = 4'hF;
         sb = 1'b1; sa = 5'(a);
         step();
      end
      idle_inputs();
      ra = 5'd6; rb = 5'd31;
      #2;
      chk("prefill r6 nonzero", {31'b0, (rda_n != 0)}, 32'h1);
      chk("prefill pend r6", {31'b0, pa_n}, 32'h1);
      step();

      scrub_req = 1'b1;
      busy_cnt_b = 0; busy_cnt_n = 0; done_cnt_b = 0; done_cnt_n = 0; done_at = -1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         scrub_req = 1'b0;
         we = (c == 20); wa = 5'd3; wd = 32'hDEADBEEF; be = 4'hF;
         sb = (c == 20); sa = 5'd4; ra = 5'd3;
         #2;
         if (busy_b) busy_cnt_b++;
         if (busy_n) busy_cnt_n++;
         if (done_b) begin
            done_cnt_b++;
            done_at = c;
         end
         if (done_n) done_cnt_n++;
         if (c == 20) chk("sweep no bypass r3", rda_b, 32'h0);
      end
      idle_inputs();
      chk("sweep busy cycles", 32'(busy_cnt_b), 32'd32);
      chk("sweep busy cycles nb", 32'(busy_cnt_n), 32'd32);
      chk("sweep done cycles", 32'(done_cnt_b), 32'd1);
      chk("sweep done cycles nb", 32'(done_cnt_n), 32'd1);
      chk("sweep done position", 32'(done_at), 32'd32);
      $display("sweep: busy=%0d done=%0d done_at=%0d", busy_cnt_b, done_cnt_b, done_at);
      for (int a = 0; a < 32; a++) begin
         ra = 5'(a); rb = 5'(a);
         #1;
         chk($sformatf("post-sweep rd[%0d]", a), rda_b, 32'h0);
         chk($sformatf("post-sweep rd nb[%0d]", a), rdb_n, 32'h0);
         chk($sformatf("post-sweep pend[%0d]", a), {31'b0, pa_b}, 32'h0);
      end
      step();

      // ---------------- reset in the middle of a sweep ----------------
      for (int a = 1; a < 32; a++) begin
         we = 1'b1; wa = 5'(a); wd = $urandom | 32'h100; be = 4'hF;
         sb = 1'b1; sa = 5'(a);
         step();
      end
      idle_inputs();
      scrub_req = 1'b1;
      step();
      scrub_req = 1'b0;
      for (int c = 0; c < 10; c++) step();
      ra = 5'd20;
      #1;
      chk("pre-abort busy", {31'b0, busy_b}, 32'h1);
      chk("pre-abort r20 nonzero", {31'b0, (rda_b != 0)}, 32'h1);
      clear = 1'b0;
      #1;
      chk("abort busy", {31'b0, busy_b}, 32'h0);
      chk("abort busy nb", {31'b0, busy_n}, 32'h0);
      chk("abort done", {31'b0, done_b}, 32'h0);
      chk("abort r20 cleared", rda_b, 32'h0);
      for (int a = 0; a < 32; a++) begin
         ra = 5'(a); rb = 5'(a);
         #1;
         chk($sformatf("abort rd[%0d]", a), rda_b, 32'h0);
         chk($sformatf("abort pend[%0d]", a), {31'b0, pb_n}, 32'h0);
      end
      $display("abort: busy=%0d done=%0d", busy_b, done_b);
      step();
      clear = 1'b1;
      we = 1'b1; wa = 5'd12; wd = 32'h00000077; be = 4'hF;
      step();
      idle_inputs();
      ra = 5'd12;
      #2;
      chk("first write after reset", rda_n, 32'h00000077);
      done_cnt_b = 0; busy_cnt_b = 0;
      for (int c = 0; c < 6; c++) begin
         if (done_b || done_n) done_cnt_b++;
         if (busy_b || busy_n) busy_cnt_b++;
         step();
      end
      chk("no done after abort", 32'(done_cnt_b), 32'd0);
      chk("no busy after abort", 32'(busy_cnt_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32: register width in bits, a multiple of 8.
REQ-002 The block SHALL provide parameter NREGS, default 32: register count, a power of two and at least 2.
REQ-003 The block SHALL provide parameter AW, default 5: address width, equal to log2(NREGS).
REQ-004 The block SHALL provide parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-005 The block SHALL provide parameter BYPASS, default 1: when 1, write data is forwarded to reads in the same cycle.
REQ-006 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL provide port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL provide port wr_en, input, 1 bit: write request.
REQ-009 The block SHALL provide port wr_addr, input, AW bits: write address.
REQ-010 The block SHALL provide port wr_data, input, XLEN bits: write data.
REQ-011 The block SHALL provide port wr_be, input, XLEN/8 bits: byte write enables; bit k covers bits 8k+7 to 8k.
REQ-012 The block SHALL provide ports rd_addr_a and rd_addr_b, input, AW bits each: read addresses.
REQ-013 The block SHALL provide ports rd_data_a and rd_data_b, output, XLEN bits each: read data.
REQ-014 The block SHALL provide port sb_set, input, 1 bit, and port sb_addr, input, AW bits: mark a register as having a write outstanding.
REQ-015 The block SHALL provide ports pend_a and pend_b, output, 1 bit each: outstanding-write (scoreboard) bit of rd_addr_a and rd_addr_b respectively.
REQ-016 The block SHALL provide port scrub_req, input, 1 bit: start a sweep that clears every register.
REQ-017 The block SHALL provide port scrub_busy, output, 1 bit: sweep in progress.
REQ-018 The block SHALL provide port scrub_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 Reads SHALL be combinational: zero latency from address to data.
REQ-020 A write SHALL occur at the rising edge when wr_en=1 and the FSM is IDLE; only bytes with wr_be=1 are updated, all other bytes hold.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded, rd_data of address 0 SHALL be 0, and pend of address 0 SHALL be 0.
REQ-022 With BYPASS=1, FSM IDLE, wr_en=1 and wr_addr equal to a read address (and not the zero register), that read port SHALL output the merged value: new bytes where wr_be=1, stored bytes elsewhere.
REQ-023 With BYPASS=0, reads SHALL return stored contents only; a new value is visible the cycle after the write.
REQ-024 Scoreboard: sb_set=1 in IDLE SHALL set pending[sb_addr] at the clock edge.
REQ-025 A write accepted per REQ-020 SHALL clear pending[wr_addr], whatever the value of wr_be, including wr_be=0.
REQ-026 When sb_set and an accepted write target the same address in the same cycle, set SHALL win and the bit ends at 1.
REQ-027 pend_a and pend_b SHALL reflect the stored pending bits combinationally, with no bypass of same-cycle sb_set.
REQ-028 The scrub FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-029 In IDLE, scrub_req=1 SHALL move the FSM to SWEEP with the counter cnt set to 0; in all other states scrub_req SHALL be ignored.
REQ-030 In SWEEP, each cycle SHALL write 0 to register cnt, clear pending[cnt] and increment cnt; when cnt=NREGS-1 the FSM SHALL move to DONE.
REQ-031 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-032 scrub_busy SHALL be 1 in SWEEP only; scrub_done SHALL be 1 in DONE only; a sweep therefore gives NREGS busy cycles followed by 1 done cycle.
REQ-033 In SWEEP and DONE, wr_en and sb_set SHALL be ignored and bypass SHALL be disabled.
REQ-034 Reads during a sweep SHALL return current stored contents, partially cleared.
REQ-035 cnt SHALL be AW bits wide and SHALL NOT wrap past NREGS-1 inside a sweep.

Reset
REQ-036 clear=0 SHALL immediately, without waiting for a clock edge, set all registers to 0, all pending bits to 0, the FSM to IDLE and cnt to 0.
REQ-037 While clear=0, scrub_busy and scrub_done SHALL be 0.
REQ-038 An assertion of clear during SWEEP SHALL abort the sweep with no scrub_done pulse.
REQ-039 After clear deasserts, the first edge SHALL accept writes normally.

Verification
REQ-040 The bench SHALL cover byte enables: write 0xAABBCCDD to r5 with wr_be=1111, then 0x11223344 with wr_be=0101 -> r5=0xAA22CC44.
REQ-041 The bench SHALL cover bypass: BYPASS=1, rd_addr_a=7, r7=0, wr_en=1, wr_addr=7, wr_data=0x12345678, wr_be=0011 -> rd_data_a=0x00005678 in the same cycle; with BYPASS=0 -> 0 that cycle and 0x00005678 the next.
REQ-042 The bench SHALL cover x0: write 0xFFFFFFFF to r0 and set sb on r0 -> rd_data=0 and pend=0.
REQ-043 The bench SHALL cover the scoreboard: sb_set r9 -> pend=1; in one cycle write r9 with wr_be=0 plus sb_set r9 -> pend stays 1; write r9 without sb_set -> pend=0.
REQ-044 The bench SHALL cover a sweep: fill all registers with nonzero values, pulse scrub_req -> scrub_busy=1 for 32 cycles, scrub_done=1 for 1 cycle, all registers 0, and a write during the sweep lost.
REQ-045 The bench SHALL cover reset mid-sweep: clear=0 at sweep cycle 10 -> immediately all registers 0, scrub_busy=0, and no scrub_done pulse.
